// File: rtl/mem_copy_pkg.sv
// mem_copy_pkg: shared state encoding and default widths for mem_copy_engine
package mem_copy_pkg;
   localparam int W_DEF = 8;
   localparam int A_DEF = 8;
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
endpackage

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: byte-at-a-time memory copy initiator (READ then WRITE per byte); define MEMCPY_CHECKSUM_EN to add a Checksum output
module mem_copy_engine
   import mem_copy_pkg::*;
#(
   parameter int W = W_DEF,
   parameter int A = A_DEF
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Start,
   input  logic [A-1:0] SrcAddr,
   input  logic [A-1:0] DstAddr,
   input  logic [A-1:0] Len,
   output logic         Busy,
   output logic         Done,
   output logic [A-1:0] DataAddress,
   output logic         WriteEn,
   output logic [W-1:0] DataIn,
   input  logic [W-1:0] DataOut
`ifdef MEMCPY_CHECKSUM_EN
   ,
   output logic [W-1:0] Checksum
`endif
);
   state_t state;
   logic [A-1:0] src, dst, cnt;
   logic [W-1:0] hold;
   // sequencer and pointer/count datapath; pointers wrap naturally modulo 2**A
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
         src   <= '0;
         dst   <= '0;
         cnt   <= '0;
         hold  <= '0;
      end else begin
         case (state)
            IDLE: if (Start) begin
               if (Len != '0) begin
                  src   <= SrcAddr;
                  dst   <= DstAddr;
                  cnt   <= Len;
                  state <= READ;
               end else
                  state <= DONE;
            end
            READ: begin
               hold  <= DataOut;
               src   <= src + 1'b1;
               state <= WRITE;
            end
            WRITE: begin
               dst   <= dst + 1'b1;
               cnt   <= cnt - 1'b1;
               state <= (cnt == A'(1)) ? DONE : READ;
            end
            default: state <= IDLE;
         endcase
      end
   end
   // memory-side outputs decoded from state; write is masked on the reset edge
   always_comb begin
      Busy        = (state == READ) || (state == WRITE);
      Done        = state == DONE;
      WriteEn     = (state == WRITE) && !Reset;
      DataAddress = (state == READ) ? src : (state == WRITE) ? dst : '0;
      DataIn      = (state == WRITE) ? hold : '0;
   end
`ifdef MEMCPY_CHECKSUM_EN
   // running sum of every byte written, restarted on each accepted Start
   always_ff @(posedge Clk) begin
      if (Reset || (state == IDLE && Start))
         Checksum <= '0;
      else if (state == WRITE)
         Checksum <= Checksum + hold;
   end
`endif
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed + randomized checks of mem_copy_engine against a byte-array reference model
module tb_mem_copy_engine;
   localparam int W = 8;
   localparam int A = 8;
   logic         Clk = 1'b0;
   logic         Reset, Start;
   logic [A-1:0] SrcAddr, DstAddr, Len, DataAddress;
   logic         Busy, Done, WriteEn;
   logic [W-1:0] DataIn, DataOut;
`ifdef MEMCPY_CHECKSUM_EN
   logic [W-1:0] Checksum;
`endif
   logic [W-1:0] mem [256];
   logic [W-1:0] mdl [256];
   logic         tb_we;
   logic [7:0]   tb_addr, tb_data;
   int compared = 0;
   int mismatched = 0;

   mem_copy_engine #(.W(W), .A(A)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start),
      .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Len(Len),
      .Busy(Busy), .Done(Done), .DataAddress(DataAddress),
      .WriteEn(WriteEn), .DataIn(DataIn), .DataOut(DataOut)
`ifdef MEMCPY_CHECKSUM_EN
      , .Checksum(Checksum)
`endif
   );

   always #5 Clk = ~Clk;

   // memory: combinational read, registered write; the bench preloads through tb_we
   assign DataOut = mem[DataAddress];
   always @(posedge Clk) begin
      if (WriteEn) mem[DataAddress] <= DataIn;
      else if (tb_we) mem[tb_addr] <= tb_data;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, 32'(Busy), 0);
      check({tag, "_done"}, 32'(Done), 0);
      check({tag, "_we"}, 32'(WriteEn), 0);
      check({tag, "_addr"}, 32'(DataAddress), 0);
      check({tag, "_din"}, 32'(DataIn), 0);
   endtask

   task automatic check_cs(input string tag, input logic [7:0] exp);
`ifdef MEMCPY_CHECKSUM_EN
      check({tag, "_checksum"}, 32'(Checksum), 32'(exp));
`else
      if (exp !== exp) $display("%s", tag);
`endif
   endtask

   task automatic check_mem(input string tag);
      int bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== mdl[i]) bad++;
      check({tag, "_mem_diff_bytes"}, 32'(bad), 0);
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] v);
      tb_we = 1'b1; tb_addr = a; tb_data = v;
      @(negedge Clk);
      tb_we = 1'b0;
      mdl[a] = v;
   endtask

   // junk inputs that a busy/done engine must ignore
   task automatic scramble(input bit noise);
      Start   = noise ? 1'($urandom) : 1'b0;
      SrcAddr = 8'($urandom);
      DstAddr = 8'($urandom);
      Len     = 8'($urandom);
   endtask

   // called at a negedge with the engine IDLE; returns at a negedge with it IDLE again
   task automatic do_copy(input string tag, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l, input bit noise);
      logic [7:0] b;
      logic [7:0] sum = 0;
      int i;
      Start = 1'b1; SrcAddr = s; DstAddr = d; Len = l;
      @(negedge Clk);
      for (int c = 0; c < 2 * int'(l); c++) begin
         i = c / 2;
         check({tag, "_busy"}, 32'(Busy), 1);
         check({tag, "_done_early"}, 32'(Done), 0);
         if (c % 2 == 0) begin
            check({tag, "_rd_addr"}, 32'(DataAddress), 32'(8'(s + i)));
            check({tag, "_rd_we"}, 32'(WriteEn), 0);
         end else begin
            b = mdl[8'(s + i)];
            check({tag, "_wr_addr"}, 32'(DataAddress), 32'(8'(d + i)));
            check({tag, "_wr_we"}, 32'(WriteEn), 1);
            check({tag, "_wr_data"}, 32'(DataIn), 32'(b));
            mdl[8'(d + i)] = b;
            sum += b;
         end
         scramble(noise);
         @(negedge Clk);
      end
      check({tag, "_done"}, 32'(Done), 1);
      check({tag, "_busy_at_done"}, 32'(Busy), 0);
      check({tag, "_we_at_done"}, 32'(WriteEn), 0);
      check_cs({tag, "_done"}, sum);
      check_mem(tag);
      scramble(noise);
      @(negedge Clk);
      check_idle({tag, "_after"});
      check_cs({tag, "_after"}, sum);
      Start = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; SrcAddr = '0; DstAddr = '0; Len = '0;
      tb_we = 1'b0; tb_addr = '0; tb_data = '0;
      repeat (2) @(negedge Clk);
      check_idle("reset");
      check_cs("reset", 0);
      Reset = 1'b0;
      for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
      check_mem("preload");
      // basic copy
      poke(8'h00, 8'd7); poke(8'h01, 8'd2); poke(8'h02, 8'd3);
      do_copy("basic", 8'h00, 8'h10, 8'd3, 1'b0);
      check("basic_byte0", 32'(mem[8'h10]), 7);
      check("basic_byte2", 32'(mem[8'h12]), 3);
      // zero length, then back-to-back starts
      do_copy("zero", 8'h40, 8'h50, 8'd0, 1'b0);
      do_copy("wrap", 8'hFE, 8'h7F, 8'd4, 1'b1);
      poke(8'h20, 8'hAB);
      do_copy("overlap", 8'h20, 8'h21, 8'd4, 1'b0);
      check("overlap_last", 32'(mem[8'h24]), 32'hAB);
      do_copy("same", 8'h30, 8'h30, 8'd5, 1'b1);
      do_copy("b2b", 8'h31, 8'hC0, 8'd2, 1'b1);
      // reset after the second write of a 5-byte copy
      Start = 1'b1; SrcAddr = 8'h60; DstAddr = 8'h90; Len = 8'd5;
      @(negedge Clk);
      Start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check("abort_busy", 32'(Busy), 1);
         if (c % 2 == 1) mdl[8'h90 + c / 2] = mdl[8'h60 + c / 2];
         @(negedge Clk);
      end
      Reset = 1'b1;
      @(negedge Clk);
      check_idle("abort_reset");
      check_cs("abort_reset", 0);
      Reset = 1'b0;
      @(negedge Clk);
      check_idle("abort_after");
      check_mem("abort");
      // randomized copies with junk Start pulses while busy
      for (int k = 0; k < 12; k++)
         do_copy("rand", 8'($urandom), 8'($urandom), 8'($urandom_range(0, 40)), 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
